adc_capture_serializer: RTL and testbench



---
 rtl/adc_capture_pkg.sv | 28 ++
 rtl/adc_capture_ram.sv | 31 +++
 rtl/adc_capture_serializer.sv | 209 ++++++++++++++++++++
 tb/tb_adc_capture_serializer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the triggered ADC burst capture and serializer.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StPost,
        StReadout
    } cap_state_e;

    // Widest sample container the lane helper accepts.
    localparam int unsigned MaxSampleBits = 64;

    // Register width for a count/index of n values, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Right-align the ADC_BITS significant MSBs of a zero-extended sample container.
    function automatic logic [MaxSampleBits-1:0] lane_msbs(
        input logic [MaxSampleBits-1:0] lane,
        input int unsigned              sample_bits,
        input int unsigned              adc_bits
    );
        return lane >> (sample_bits - adc_bits);
    endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
module adc_capture_ram #(
    parameter int unsigned Width = 96,
    parameter int unsigned Depth = 64,
    parameter int unsigned AddrW = 6
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Storage and read register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture_serializer.sv
// Captures a pre/post-triggered burst from one RFDC channel and replays it one
// sample per clock, oldest first, towards an ILA probe.
module adc_capture_serializer
    import adc_capture_pkg::*;
#(
    parameter int unsigned NCHAN       = 1,
    parameter int unsigned NSAMP       = 8,
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned ADC_BITS    = 12,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned PRETRIG     = 16
) (
    input  logic                               adc_clk_i,
    input  logic                               adc_rst_i,
    input  logic [NCHAN*NSAMP*SAMPLE_BITS-1:0] adc_in_i,
    input  logic                               arm_i,
    input  logic [width_of(NCHAN)-1:0]         chan_sel_i,
    input  logic                               trigger_in_i,
    output logic                               trigger_ack_o,
    output logic [ADC_BITS-1:0]                adc_out_o,
    output logic                               adc_valid_o,
    output logic                               adc_last_o,
    output logic                               busy_o
);

    localparam int unsigned ChanW = width_of(NCHAN);
    localparam int unsigned PtrW  = width_of(DEPTH);
    localparam int unsigned PreW  = width_of(PRETRIG + 1);
    localparam int unsigned LaneW = width_of(NSAMP);
    localparam int unsigned WordW = NSAMP * ADC_BITS;

    cap_state_e          state_q, state_d;
    logic [ChanW-1:0]    chan_q, chan_d;
    logic [PreW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [PtrW-1:0]     post_cnt_q, post_cnt_d;
    logic [PtrW-1:0]     wptr_q, wptr_d;
    logic [PtrW-1:0]     rd_addr_q, rd_addr_d;
    logic [PtrW-1:0]     word_cnt_q, word_cnt_d;
    logic [LaneW-1:0]    lane_q, lane_d;
    logic                primed_q, primed_d;
    logic [ADC_BITS-1:0] adc_out_q, adc_out_d;
    logic                adc_valid_q, adc_valid_d;
    logic                adc_last_q, adc_last_d;
    logic                trig_ack_q;

    logic                       ram_we;
    logic                       ram_re;
    logic [WordW-1:0]           ram_wdata;
    logic [WordW-1:0]           ram_rdata;
    logic [ADC_BITS-1:0]        rd_lane;
    logic [NCHAN-1:0][WordW-1:0] chan_word;

    // Pack the significant bits of every lane of every channel into buffer words.
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        for (genvar k = 0; k < NSAMP; k++) begin : g_lane
            assign chan_word[c][k*ADC_BITS +: ADC_BITS] = ADC_BITS'(lane_msbs(
                MaxSampleBits'(adc_in_i[(c*NSAMP+k)*SAMPLE_BITS +: SAMPLE_BITS]),
                SAMPLE_BITS, ADC_BITS));
        end
    end

    always_comb begin
        ram_wdata = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (chan_q == ChanW'(c)) begin
                ram_wdata = chan_word[c];
            end
        end
    end

    always_comb begin
        rd_lane = '0;
        for (int unsigned k = 0; k < NSAMP; k++) begin
            if (lane_q == LaneW'(k)) begin
                rd_lane = ram_rdata[k*ADC_BITS +: ADC_BITS];
            end
        end
    end

    adc_capture_ram #(
        .Width (WordW),
        .Depth (DEPTH),
        .AddrW (PtrW)
    ) u_ram (
        .clk_i   (adc_clk_i),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        wptr_d      = wptr_q;
        rd_addr_d   = rd_addr_q;
        word_cnt_d  = word_cnt_q;
        lane_d      = lane_q;
        primed_d    = primed_q;
        adc_out_d   = '0;
        adc_valid_d = 1'b0;
        adc_last_d  = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm_i) begin
                    state_d   = StArmed;
                    chan_d    = (32'(chan_sel_i) < NCHAN) ? chan_sel_i : '0;
                    pre_cnt_d = '0;
                end
            end
            StArmed: begin
                ram_we = 1'b1;
                wptr_d = wptr_q + PtrW'(1);
                if (pre_cnt_q != PreW'(PRETRIG)) begin
                    pre_cnt_d = pre_cnt_q + PreW'(1);
                end
                if (trigger_in_i && (pre_cnt_q == PreW'(PRETRIG))) begin
                    // Oldest kept word is PRETRIG slots behind the trigger word.
                    rd_addr_d  = wptr_q - PtrW'(PRETRIG);
                    post_cnt_d = PtrW'(1);
                    word_cnt_d = '0;
                    lane_d     = '0;
                    primed_d   = 1'b0;
                    state_d    = (DEPTH - PRETRIG == 1) ? StReadout : StPost;
                end
            end
            StPost: begin
                ram_we     = 1'b1;
                wptr_d     = wptr_q + PtrW'(1);
                post_cnt_d = post_cnt_q + PtrW'(1);
                if (post_cnt_q == PtrW'(DEPTH - PRETRIG - 1)) begin
                    state_d = StReadout;
                end
            end
            StReadout: begin
                if (adc_last_q) begin
                    state_d = StIdle;
                end else if (!primed_q) begin
                    ram_re    = 1'b1;
                    rd_addr_d = rd_addr_q + PtrW'(1);
                    primed_d  = 1'b1;
                end else begin
                    adc_valid_d = 1'b1;
                    adc_out_d   = rd_lane;
                    if (lane_q == LaneW'(NSAMP - 1)) begin
                        // Fetch the next word so it lands exactly as this one drains.
                        lane_d = '0;
                        if (word_cnt_q == PtrW'(DEPTH - 1)) begin
                            adc_last_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + PtrW'(1);
                            ram_re     = 1'b1;
                            rd_addr_d  = rd_addr_q + PtrW'(1);
                        end
                    end else begin
                        lane_d = lane_q + LaneW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q     <= StIdle;
            chan_q      <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            wptr_q      <= '0;
            rd_addr_q   <= '0;
            word_cnt_q  <= '0;
            lane_q      <= '0;
            primed_q    <= 1'b0;
            adc_out_q   <= '0;
            adc_valid_q <= 1'b0;
            adc_last_q  <= 1'b0;
            trig_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            wptr_q      <= wptr_d;
            rd_addr_q   <= rd_addr_d;
            word_cnt_q  <= word_cnt_d;
            lane_q      <= lane_d;
            primed_q    <= primed_d;
            adc_out_q   <= adc_out_d;
            adc_valid_q <= adc_valid_d;
            adc_last_q  <= adc_last_d;
            trig_ack_q  <= trigger_in_i;
        end
    end

    assign trigger_ack_o = trig_ack_q;
    assign adc_out_o     = adc_out_q;
    assign adc_valid_o   = adc_valid_q;
    assign adc_last_o    = adc_last_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_adc_capture_serializer.sv
// Directed bench: default, four-channel and minimum-depth instances share one clock.
module tb_adc_capture_serializer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_bad = 0;
    int   which = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] din_ramp;
    logic [511:0] din_chan;

    // Ramp: lane k of the word sampled at cyc holds (cyc*8+k) in its top 12 bits.
    always_comb begin
        din_ramp = '0;
        for (int k = 0; k < 8; k++) din_ramp[k*16 +: 16] = 16'((cyc * 8 + k) << 4);
    end

    always_comb begin
        din_chan = '0;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 8; k++) din_chan[(n*8+k)*16 +: 16] = 16'((n << 12) | (k << 4));
        end
    end

    logic        arm_v   [3];
    logic        trig_v  [3];
    logic [11:0] out_v   [3];
    logic        valid_v [3];
    logic        last_v  [3];
    logic        busy_v  [3];
    logic        ack_v   [3];
    logic [1:0]  sel4;

    adc_capture_serializer u_dut_def (
        .adc_clk_i     (clk),
        .adc_rst_i     (rst),
        .adc_in_i      (din_ramp),
        .arm_i         (arm_v[0]),
        .chan_sel_i    (1'b0),
        .trigger_in_i  (trig_v[0]),
        .trigger_ack_o (ack_v[0]),
        .adc_out_o     (out_v[0]),
        .adc_valid_o   (valid_v[0]),
        .adc_last_o    (last_v[0]),
        .busy_o        (busy_v[0])
    );

    adc_capture_serializer #(
        .NCHAN (4)
    ) u_dut_ch4 (
        .adc_clk_i     (clk),
        .adc_rst_i     (rst),
        .adc_in_i      (din_chan),
        .arm_i         (arm_v[1]),
        .chan_sel_i    (sel4),
        .trigger_in_i  (trig_v[1]),
        .trigger_ack_o (ack_v[1]),
        .adc_out_o     (out_v[1]),
        .adc_valid_o   (valid_v[1]),
        .adc_last_o    (last_v[1]),
        .busy_o        (busy_v[1])
    );

    adc_capture_serializer #(
        .DEPTH   (4),
        .PRETRIG (0)
    ) u_dut_min (
        .adc_clk_i     (clk),
        .adc_rst_i     (rst),
        .adc_in_i      (din_ramp),
        .arm_i         (arm_v[2]),
        .chan_sel_i    (1'b0),
        .trigger_in_i  (trig_v[2]),
        .trigger_ack_o (ack_v[2]),
        .adc_out_o     (out_v[2]),
        .adc_valid_o   (valid_v[2]),
        .adc_last_o    (last_v[2]),
        .busy_o        (busy_v[2])
    );

    logic [11:0] s_out;
    logic        s_valid, s_last, s_busy;

    always_comb begin
        s_out   = out_v[which];
        s_valid = valid_v[which];
        s_last  = last_v[which];
        s_busy  = busy_v[which];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // All stimulus tasks are entered and left at a falling edge.
    task automatic arm_pulse(input int d, output int a);
        arm_v[d] = 1'b1;
        a = cyc;
        @(negedge clk);
        arm_v[d] = 1'b0;
    endtask

    task automatic trig_pulse(input int d, output int t);
        trig_v[d] = 1'b1;
        t = cyc;
        @(negedge clk);
        trig_v[d] = 1'b0;
        check("trigger_ack", int'(ack_v[d]), 1);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic collect(input int first, input int n, input int deadline, input bit chan_mode);
        int k, errs, gaps, nlast, last_pos, exp0;
        k = 0;
        while (!s_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!s_valid) begin
            check("first_valid_timeout", 0, 1);
            return;
        end
        check("first_valid_latency", int'(cyc <= deadline), 1);
        exp0 = chan_mode ? 32'h200 : (first & 32'hFFF);
        check("first_sample", int'(s_out), exp0);
        errs = 0; gaps = 0; nlast = 0; last_pos = -1;
        for (int i = 0; i < n; i++) begin
            int exp;
            exp = chan_mode ? (32'h200 + i % 8) : ((first + i) & 32'hFFF);
            if (!s_valid) gaps++;
            if (int'(s_out) != exp) errs++;
            if (s_last) begin
                nlast++;
                last_pos = i;
            end
            @(negedge clk);
        end
        check("burst_gaps", gaps, 0);
        check("burst_data_errors", errs, 0);
        check("last_count", nlast, 1);
        check("last_position", last_pos, n - 1);
        check("after_burst_valid", int'(s_valid), 0);
        check("after_burst_busy", int'(s_busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, t, dummy;
        for (int d = 0; d < 3; d++) begin
            arm_v[d]  = 1'b0;
            trig_v[d] = 1'b0;
        end
        sel4 = 2'd0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out", int'(out_v[0]), 0);
        check("reset_valid", int'(valid_v[0]), 0);
        check("reset_last", int'(last_v[0]), 0);
        check("reset_busy", int'(busy_v[0]), 0);
        check("reset_ack", int'(ack_v[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        // Trigger while idle is acknowledged but does nothing else.
        trig_pulse(0, dummy);
        @(negedge clk);
        check("ack_drops", int'(ack_v[0]), 0);
        check("idle_trigger_busy", int'(busy_v[0]), 0);

        // Default capture: early trigger ignored, arm in POST and READOUT ignored.
        which = 0;
        arm_pulse(0, a);
        check("armed_busy", int'(s_busy), 1);
        wait_cyc(a + 5);
        trig_pulse(0, dummy);
        check("early_trigger_busy", int'(s_busy), 1);
        wait_cyc(a + 17);
        trig_pulse(0, t);
        arm_pulse(0, dummy);
        fork
            collect((t - 16) * 8, 512, t + 51, 1'b0);
            begin
                repeat (100) @(negedge clk);
                arm_v[0] = 1'b1;
                @(negedge clk);
                arm_v[0] = 1'b0;
            end
        join
        repeat (2) @(negedge clk);

        // Reset in the middle of readout, then a fresh capture.
        arm_pulse(0, a);
        wait_cyc(a + 17);
        trig_pulse(0, t);
        repeat (60) @(negedge clk);
        check("mid_readout_valid", int'(s_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", int'(s_valid), 0);
        check("abort_busy", int'(s_busy), 0);
        rst = 1'b0;
        @(negedge clk);
        arm_pulse(0, a);
        wait_cyc(a + 17);
        trig_pulse(0, t);
        collect((t - 16) * 8, 512, t + 51, 1'b0);

        // Four channels, channel 2 latched; later chan_sel changes have no effect.
        which = 1;
        sel4  = 2'd2;
        arm_pulse(1, a);
        sel4 = 2'd3;
        wait_cyc(a + 10);
        sel4 = 2'd1;
        wait_cyc(a + 17);
        trig_pulse(1, t);
        sel4 = 2'd0;
        collect(0, 512, t + 51, 1'b1);

        // DEPTH=4, PRETRIG=0: trigger on the first armed cycle, 32 samples.
        which = 2;
        arm_pulse(2, a);
        trig_pulse(2, t);
        collect(t * 8, 32, t + 7, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
